int8_dot_seq: RTL and testbench
===============================

Name: int8_dot_seq

Overview:
- Sequencing controller for the combinational int8 32-lane dot-product MAC.
- Accepts a command (chunk count, signed bias) and consumes that many 32-lane operand beats from a valid/ready stream.
- Per beat, drives the MAC with the registered running sum and captures its output. Returns one signed 24-bit result over a valid/ready port.
- Sits between the operand buffer/fetch logic and the output writeback of the matrix accelerator; the MAC itself is instantiated outside this block.

Parameters:
- LEN_W, 8, width of chunk-count field (max 2^LEN_W-1 beats per command)
- ACC_W, 24, accumulator/result width; must match MAC partial-sum width
- VEC_W, 264, operand vector width (33 byte lanes; lane 0 unused by MAC)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous abort, active high
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accept
- cmd_len  in  LEN_W  number of operand beats (unsigned)
- cmd_bias  in  ACC_W  signed initial accumulator value
- op_valid  in  1  operand beat valid
- op_ready  out  1  operand beat accept
- op_a  in  VEC_W  operand A, lanes 1..32 active
- op_b  in  VEC_W  operand B, lanes 1..32 active
- mac_en  out  1  MAC enable
- mac_a  out  VEC_W  to MAC a_vec
- mac_b  out  VEC_W  to MAC b_vec
- mac_psum_in  out  ACC_W  to MAC partial_sum_in
- mac_psum_out  in  ACC_W  from MAC partial_sum_out
- res_valid  out  1  result valid
- res_ready  in  1  result accept
- res_data  out  ACC_W  signed result
- busy  out  1  high in RUN or DONE

Behaviour:
- Clocking and reset: one clock domain. Reset is asynchronous, active-low on rst_n.
- Reset state: state=IDLE, acc=0, remaining=0. All outputs 0 except cmd_ready=1.
- Reset asserted mid-command discards everything; no result is produced.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - cmd_ready=1, op_ready=0, res_valid=0.
  - On cmd_valid: acc<=cmd_bias, remaining<=cmd_len.
  - Next state is RUN if cmd_len!=0, else DONE.
- RUN:
  - op_ready=1, mac_en=1.
  - mac_a/mac_b = op_a/op_b with byte lane 0 forced to 0x00; mac_psum_in=acc.
  - On op_valid&op_ready: acc<=mac_psum_out, remaining<=remaining-1.
  - If remaining==1 on that beat, go to DONE. Cycles without op_valid stall with no state change.
- DONE:
  - res_valid=1, res_data=acc, held stable until res_ready.
  - On res_ready: cmd_ready=1 in the same cycle (combinational: cmd_ready = IDLE | (DONE & res_ready)).
  - If cmd_valid is also high, the new command loads exactly as in IDLE; otherwise go to IDLE.
- MAC drive outside RUN: mac_en=0, mac_a=mac_b=0, mac_psum_in=0. op_valid outside RUN is ignored (op_ready=0).
- Latency: command accepted at cycle 0, beats with op_valid held occupy cycles 1..N, res_valid at cycle N+1. cmd_len=0 gives res_valid=cmd_bias at cycle 1.
- Arithmetic: two's-complement modulo 2^ACC_W. The MAC wraps; the controller does not saturate or flag overflow.
- flush:
  - Next state IDLE, acc<=0, remaining<=0. Any in-flight beat and any pending result are discarded.
  - flush has priority over every handshake in the same cycle. A cmd or op handshake coinciding with flush is not consumed (cmd_ready=op_ready=0 while flush=1).
- busy = (state!=IDLE).

Test Plan:
- Single beat: cmd_len=1, bias=0, lanes1..32 a=1 b=2, lane0 a=b=0x7F → res_data=64 at cycle 2; lane 0 contributes nothing.
- Multi beat with bias: cmd_len=3, bias=-100, every beat a=3 b=-1 on all active lanes → res_data=-388 (0xFFFE7C) at cycle 4.
- Zero length: cmd_len=0, bias=5 → res_valid at cycle 1 with res_data=5; op_ready never asserted.
- Wrap: cmd_len=16, bias=0, all lanes a=b=-128 (524288 per beat) → res_data=0x800000 (-8388608).
- Backpressure/back-to-back:
  - op_valid toggled every other cycle → same result, acc unchanged on idle cycles.
  - res_ready held low 5 cycles → res_data stable, cmd_ready=0.
  - res_ready and cmd_valid asserted together → second command accepted that cycle, no IDLE bubble.
- Abort:
  - flush asserted after 2 of 4 beats → IDLE next cycle, no res_valid; next command (len=1, bias=7, zero operands) returns 7.
  - rst_n pulsed low mid-RUN → all outputs at reset values immediately, asynchronously.

Source files
------------

// File: rtl/int8_dot_seq.sv
// Sequencing controller for an external int8 32-lane dot-product MAC: loads a
// command, streams operand beats through the MAC, returns one signed result.
module int8_dot_seq #(
  parameter int LEN_W = 8,
  parameter int ACC_W = 24,
  parameter int VEC_W = 264
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [ACC_W-1:0] cmd_bias,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [VEC_W-1:0] op_a,
  input  logic [VEC_W-1:0] op_b,
  output logic             mac_en,
  output logic [VEC_W-1:0] mac_a,
  output logic [VEC_W-1:0] mac_b,
  output logic [ACC_W-1:0] mac_psum_in,
  input  logic [ACC_W-1:0] mac_psum_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ACC_W-1:0] res_data,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [ACC_W-1:0] acc_q;
  logic [LEN_W-1:0] rem_q;

  logic st_idle, st_run, st_done;
  logic cmd_fire, op_fire, res_fire;

  assign st_idle = (state_q == S_IDLE);
  assign st_run  = (state_q == S_RUN);
  assign st_done = (state_q == S_DONE);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never depends on ready. flush drops every ready so no
  // transfer is consumed in a flush cycle.
  assign cmd_ready = ~flush & (st_idle | (st_done & res_ready));
  assign op_ready  = ~flush & st_run;
  assign cmd_fire  = cmd_valid & cmd_ready;
  assign op_fire   = op_valid & op_ready;
  assign res_fire  = res_valid & res_ready & ~flush;

  // Byte lane 0 carries no MAC product, so it is zeroed before the MAC.
  assign mac_en      = st_run;
  assign mac_a       = st_run ? {op_a[VEC_W-1:8], 8'h00} : '0;
  assign mac_b       = st_run ? {op_b[VEC_W-1:8], 8'h00} : '0;
  assign mac_psum_in = st_run ? acc_q : '0;

  assign res_valid = st_done;
  assign res_data  = st_done ? acc_q : '0;
  assign busy      = ~st_idle;
  assign dbg_state = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
    end else if (flush) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_fire) begin
            acc_q   <= cmd_bias;
            rem_q   <= cmd_len;
            state_q <= (cmd_len != '0) ? S_RUN : S_DONE;
          end
        end
        S_RUN: begin
          if (op_fire) begin
            acc_q <= mac_psum_out;
            rem_q <= rem_q - LEN_W'(1);
            if (rem_q == LEN_W'(1)) state_q <= S_DONE;
          end
        end
        S_DONE: begin
          // A command arriving with the result handshake loads without an
          // IDLE bubble.
          if (res_fire) begin
            if (cmd_fire) begin
              acc_q   <= cmd_bias;
              rem_q   <= cmd_len;
              state_q <= (cmd_len != '0) ? S_RUN : S_DONE;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_int8_dot_seq.sv
// Bench for int8_dot_seq with a behavioural MAC; directed commands push
// expected results, a negedge monitor pops and compares them.
module tb_int8_dot_seq;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [7:0]   cmd_len;
  logic [23:0]  cmd_bias;
  logic         op_valid;
  logic         op_ready;
  logic [263:0] op_a;
  logic [263:0] op_b;
  logic         mac_en;
  logic [263:0] mac_a;
  logic [263:0] mac_b;
  logic [23:0]  mac_psum_in;
  logic [23:0]  mac_psum_out;
  logic         res_valid;
  logic         res_ready;
  logic [23:0]  res_data;
  logic         busy;
  logic [1:0]   dbg_state;

  logic [23:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  int8_dot_seq #(.LEN_W(8), .ACC_W(24), .VEC_W(264)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len), .cmd_bias(cmd_bias),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .mac_en(mac_en), .mac_a(mac_a), .mac_b(mac_b),
    .mac_psum_in(mac_psum_in), .mac_psum_out(mac_psum_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- external MAC model ----------------
  function automatic logic [23:0] mac_fn(input logic [263:0] a, input logic [263:0] b,
                                         input logic [23:0] p);
    int s;
    logic signed [7:0] x;
    logic signed [7:0] y;
    s = int'($signed(p));
    for (int l = 1; l < 33; l++) begin
      x = a[l*8 +: 8];
      y = b[l*8 +: 8];
      s += int'(x) * int'(y);
    end
    return s[23:0];
  endfunction

  assign mac_psum_out = mac_fn(mac_a, mac_b, mac_psum_in);

  // ---------------- helpers ----------------
  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic logic [263:0] vec(input logic [7:0] v, input logic [7:0] l0);
    logic [263:0] r;
    r = {33{v}};
    r[7:0] = l0;
    return r;
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready && !flush) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", {8'h0, res_data}, 32'hFFFF_FFFF);
      end else begin
        check("res_data", {8'h0, res_data}, {8'h0, exp_q.pop_front()});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cmd_ready();
    int t = 0;
    @(negedge clk);
    while (!cmd_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("cmd_ready_timeout", {31'h0, cmd_ready}, 32'h1);
  endtask

  task automatic wait_idle();
    int t = 0;
    @(negedge clk);
    while (busy && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("idle_timeout", {31'h0, busy}, 32'h0);
    @(posedge clk);
    #1;
  endtask

  task automatic run_cmd(input int len, input logic [23:0] bias, input logic [7:0] av,
                         input logic [7:0] bv, input logic [7:0] l0, input bit gap,
                         input logic [23:0] exp);
    logic [23:0] p_stall;
    exp_q.push_back(exp);
    cmd_valid = 1'b1;
    cmd_len   = len[7:0];
    cmd_bias  = bias;
    wait_cmd_ready();
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    for (int i = 0; i < len; i++) begin
      if (gap) begin
        op_valid = 1'b0;
        @(negedge clk);
        p_stall = mac_psum_in;
        @(posedge clk);
        #1;
      end
      op_a = vec(av, l0);
      op_b = vec(bv, l0);
      op_valid = 1'b1;
      @(negedge clk);
      check("op_ready_run", {31'h0, op_ready}, 32'h1);
      if (i == 0) begin
        check("mac_lane0_zero", {24'h0, mac_a[7:0]}, 32'h0);
        check("mac_lane1_pass", {24'h0, mac_b[15:8]}, {24'h0, bv});
      end
      if (gap) check("acc_hold_on_stall", {8'h0, mac_psum_in}, {8'h0, p_stall});
      @(posedge clk);
      #1;
    end
    op_valid = 1'b0;
    op_a = '0;
    op_b = '0;
    @(negedge clk);
    check("res_valid_latency", {31'h0, res_valid}, 32'h1);
    if (len == 0) check("op_ready_zero_len", {31'h0, op_ready}, 32'h0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b1; flush = 1'b0; cmd_valid = 1'b0; cmd_len = '0; cmd_bias = '0;
    op_valid = 1'b0; op_a = '0; op_b = '0; res_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_cmd_ready", {31'h0, cmd_ready}, 32'h1);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_res_valid", {31'h0, res_valid}, 32'h0);
    check("rst_mac_en", {31'h0, mac_en}, 32'h0);
    check("rst_state", {30'h0, dbg_state}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single beat, lane 0 poisoned with 0x7F: 32 * 1 * 2 = 64
    run_cmd(1, 24'd0, 8'd1, 8'd2, 8'h7F, 1'b0, 24'd64);
    wait_idle();
    // Three beats of 32 * (3 * -1) plus bias -100 = -388
    run_cmd(3, -24'sd100, 8'd3, 8'hFF, 8'h00, 1'b0, 24'hFFFE7C);
    wait_idle();
    // Zero length returns bias in cycle 1
    run_cmd(0, 24'd5, 8'd0, 8'd0, 8'h00, 1'b0, 24'd5);
    wait_idle();
    // 16 beats of 32 * 16384 wrap to 0x800000
    run_cmd(16, 24'd0, 8'h80, 8'h80, 8'h80, 1'b0, 24'h800000);
    wait_idle();
    // op_valid toggled every other cycle gives the same result
    run_cmd(3, -24'sd100, 8'd3, 8'hFF, 8'h00, 1'b1, 24'hFFFE7C);
    wait_idle();

    // Result backpressure: 10 + 32 * 1 = 42 held stable
    res_ready = 1'b0;
    run_cmd(1, 24'd10, 8'd1, 8'd1, 8'h00, 1'b0, 24'd42);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_res_valid", {31'h0, res_valid}, 32'h1);
      check("bp_res_data", {8'h0, res_data}, 32'd42);
      check("bp_cmd_ready", {31'h0, cmd_ready}, 32'h0);
    end
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    wait_idle();

    // Back-to-back: result handshake and zero-length command together
    res_ready = 1'b0;
    run_cmd(1, 24'd0, 8'd1, 8'd2, 8'h00, 1'b0, 24'd64);
    @(posedge clk);
    #1;
    exp_q.push_back(24'hFFFFF7);
    cmd_valid = 1'b1; cmd_len = 8'd0; cmd_bias = 24'hFFFFF7; res_ready = 1'b1;
    @(negedge clk);
    check("b2b_cmd_ready", {31'h0, cmd_ready}, 32'h1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    check("b2b_no_bubble", {31'h0, res_valid}, 32'h1);
    check("b2b_busy", {31'h0, busy}, 32'h1);
    wait_idle();

    // Flush after 2 of 4 beats: nothing returned, then a clean command
    cmd_valid = 1'b1; cmd_len = 8'd4; cmd_bias = 24'd1;
    wait_cmd_ready();
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    op_a = vec(8'd2, 8'd0); op_b = vec(8'd2, 8'd0); op_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    check("flush_op_ready", {31'h0, op_ready}, 32'h0);
    check("flush_cmd_ready", {31'h0, cmd_ready}, 32'h0);
    @(posedge clk);
    #1;
    flush = 1'b0; op_valid = 1'b0;
    @(negedge clk);
    check("flush_idle", {31'h0, busy}, 32'h0);
    check("flush_no_res", {31'h0, res_valid}, 32'h0);
    @(posedge clk);
    #1;
    run_cmd(1, 24'd7, 8'd0, 8'd0, 8'h00, 1'b0, 24'd7);
    wait_idle();

    // Asynchronous reset mid-RUN
    cmd_valid = 1'b1; cmd_len = 8'd4; cmd_bias = 24'd3;
    wait_cmd_ready();
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    op_a = vec(8'd1, 8'd0); op_b = vec(8'd1, 8'd0); op_valid = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", {31'h0, busy}, 32'h0);
    check("arst_cmd_ready", {31'h0, cmd_ready}, 32'h1);
    check("arst_op_ready", {31'h0, op_ready}, 32'h0);
    check("arst_mac_en", {31'h0, mac_en}, 32'h0);
    check("arst_psum_in", {8'h0, mac_psum_in}, 32'h0);
    check("arst_res_valid", {31'h0, res_valid}, 32'h0);
    op_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    // Restart after reset: 1 + 2 * 32 = 65
    run_cmd(2, 24'd1, 8'd1, 8'd1, 8'h00, 1'b0, 24'd65);
    wait_idle();

    check("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
